// File: rtl/element_tree_builder.sv
// Element tree builder: turns element_parser tag/attribute strobes into a
// depth-annotated OPEN/ATTR/CLOSE/ERROR record stream behind an output FIFO.
module element_tree_builder #(
  parameter int TAG_W       = 3,
  parameter int ATYPE_W     = 3,
  parameter int AVAL_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int MAX_ATTR    = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ID_W        = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         el_active,
  input  logic                         tag_done,
  input  logic [TAG_W-1:0]             element_tag,
  input  logic                         is_closing_tag,
  input  logic                         has_attribute,
  input  logic [ATYPE_W-1:0]           attribute_type,
  input  logic [AVAL_W-1:0]            attribute_value,
  input  logic                         rec_ready,
  output logic                         rec_valid,
  output logic [1:0]                   rec_kind,
  output logic [TAG_W-1:0]             rec_tag,
  output logic [$clog2(STACK_DEPTH):0] rec_depth,
  output logic [ID_W-1:0]              rec_id,
  output logic [ATYPE_W-1:0]           rec_attr_type,
  output logic [AVAL_W-1:0]            rec_attr_value,
  output logic                         busy,
  output logic                         overrun,
  output logic [1:0]                   fsm_state
);
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (MAX_ATTR > 1) ? $clog2(MAX_ATTR) : 1;
  localparam int CNT_W = $clog2(MAX_ATTR + 1);
  localparam logic [SP_W:0]    LVL_FULL = (SP_W+1)'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_ATTR);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_OPEN_CHK  = 2'd1;
  localparam logic [1:0] S_EMIT_ATTR = 2'd2;
  localparam logic [1:0] S_CLOSE_CHK = 2'd3;

  localparam logic [1:0] K_OPEN  = 2'd0;
  localparam logic [1:0] K_ATTR  = 2'd1;
  localparam logic [1:0] K_CLOSE = 2'd2;
  localparam logic [1:0] K_ERROR = 2'd3;

  typedef struct packed {
    logic [1:0]         kind;
    logic [TAG_W-1:0]   tag;
    logic [SP_W:0]      depth;
    logic [ID_W-1:0]    id;
    logic [ATYPE_W-1:0] atype;
    logic [AVAL_W-1:0]  aval;
  } rec_t;

  logic tag_prev, attr_prev, tag_ev, attr_ev, accept;
  logic [1:0] state;

  logic [ATYPE_W-1:0] cap_type [MAX_ATTR];
  logic [AVAL_W-1:0]  cap_val  [MAX_ATTR];
  logic [CNT_W-1:0]   cap_cnt;

  logic [ATYPE_W-1:0] em_type [MAX_ATTR];
  logic [AVAL_W-1:0]  em_val  [MAX_ATTR];
  logic [TAG_W-1:0]   em_tag;
  logic [CNT_W-1:0]   em_cnt, em_idx;

  logic [TAG_W-1:0] stk_tag [STACK_DEPTH];
  logic [ID_W-1:0]  stk_id  [STACK_DEPTH];
  logic [SP_W:0]    level, lvl_dec, at_depth;
  logic [SP_W-1:0]  top_idx;
  logic [TAG_W-1:0] top_tag;
  logic [ID_W-1:0]  top_id, next_id, ovf_count, at_id;
  logic             stack_full, stack_empty;

  rec_t             mem [FIFO_DEPTH];
  rec_t             wr_rec, head, out_rec;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, do_pop, do_push, can_write, wr_en;

  assign tag_ev  = tag_done & ~tag_prev;
  assign attr_ev = has_attribute & ~attr_prev;
  assign accept  = tag_ev && (state == S_IDLE);

  assign stack_full  = (level == LVL_FULL);
  assign stack_empty = (level == '0);
  assign lvl_dec     = level - (SP_W+1)'(1);
  assign top_idx     = level[SP_W-1:0] - SP_W'(1);
  assign top_tag     = stk_tag[top_idx];
  assign top_id      = stk_id[top_idx];

  // Valid/ready: a record moves when rec_valid && rec_ready on a rising edge;
  // the head entry (and so every rec_* field) is held until that happens.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rec_valid  = !fifo_empty;
  assign do_pop     = rec_valid && rec_ready;
  assign can_write  = !fifo_full || do_pop;
  assign do_push    = wr_en && can_write;

  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign out_rec = rec_valid ? head : '0;
  assign rec_kind       = out_rec.kind;
  assign rec_tag        = out_rec.tag;
  assign rec_depth      = out_rec.depth;
  assign rec_id         = out_rec.id;
  assign rec_attr_type  = out_rec.atype;
  assign rec_attr_value = out_rec.aval;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_prev  <= 1'b0;
      attr_prev <= 1'b0;
      cap_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      tag_prev  <= tag_done;
      attr_prev <= has_attribute;
      if (!el_active) cap_cnt <= '0;
      else if (accept) cap_cnt <= attr_ev ? CNT_W'(1) : '0;
      else if (attr_ev && cap_cnt != CNT_FULL) cap_cnt <= cap_cnt + CNT_W'(1);
      if ((tag_ev && state != S_IDLE) ||
          (el_active && attr_ev && !accept && cap_cnt == CNT_FULL))
        overrun <= 1'b1;
    end
  end

  // Storage arrays carry no reset; their valid extent is tracked by counters.
  always_ff @(posedge clock) begin
    if (el_active && attr_ev) begin
      if (accept) begin
        cap_type[0] <= attribute_type;
        cap_val[0]  <= attribute_value;
      end else if (cap_cnt != CNT_FULL) begin
        cap_type[cap_cnt[IDX_W-1:0]] <= attribute_type;
        cap_val[cap_cnt[IDX_W-1:0]]  <= attribute_value;
      end
    end
    if (accept) begin
      em_type <= cap_type;
      em_val  <= cap_val;
    end
    if (state == S_OPEN_CHK && can_write && !stack_full) begin
      stk_tag[level[SP_W-1:0]] <= em_tag;
      stk_id[level[SP_W-1:0]]  <= next_id;
    end
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_rec;
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_rec = '0;
    case (state)
      S_OPEN_CHK: begin
        wr_en      = 1'b1;
        wr_rec.tag = em_tag;
        if (stack_full) begin
          wr_rec.kind  = K_ERROR;
          wr_rec.depth = LVL_FULL;
        end else begin
          wr_rec.kind  = K_OPEN;
          wr_rec.depth = level;
          wr_rec.id    = next_id;
        end
      end
      S_EMIT_ATTR: begin
        wr_en        = 1'b1;
        wr_rec.kind  = K_ATTR;
        wr_rec.tag   = em_tag;
        wr_rec.depth = at_depth;
        wr_rec.id    = at_id;
        wr_rec.atype = em_type[em_idx[IDX_W-1:0]];
        wr_rec.aval  = em_val[em_idx[IDX_W-1:0]];
      end
      S_CLOSE_CHK: begin
        // A pending overflow count absorbs the close of a never-pushed open.
        if (ovf_count == '0) begin
          wr_en = 1'b1;
          if (stack_empty) begin
            wr_rec.kind = K_ERROR;
            wr_rec.tag  = em_tag;
          end else begin
            wr_rec.kind  = (top_tag == em_tag) ? K_CLOSE : K_ERROR;
            wr_rec.tag   = top_tag;
            wr_rec.depth = lvl_dec;
            wr_rec.id    = top_id;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      level     <= '0;
      next_id   <= '0;
      ovf_count <= '0;
      em_tag    <= '0;
      em_cnt    <= '0;
      em_idx    <= '0;
      at_depth  <= '0;
      at_id     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tag_ev) begin
            em_tag <= element_tag;
            em_cnt <= is_closing_tag ? '0 : cap_cnt;
            em_idx <= '0;
            state  <= is_closing_tag ? S_CLOSE_CHK : S_OPEN_CHK;
          end
        end
        S_OPEN_CHK: begin
          if (can_write) begin
            if (stack_full) begin
              ovf_count <= ovf_count + ID_W'(1);
              state     <= S_IDLE;
            end else begin
              level    <= level + (SP_W+1)'(1);
              next_id  <= next_id + ID_W'(1);
              at_depth <= level;
              at_id    <= next_id;
              state    <= (em_cnt == '0) ? S_IDLE : S_EMIT_ATTR;
            end
          end
        end
        S_EMIT_ATTR: begin
          if (can_write) begin
            em_idx <= em_idx + CNT_W'(1);
            if (em_idx == em_cnt - CNT_W'(1)) state <= S_IDLE;
          end
        end
        S_CLOSE_CHK: begin
          if (ovf_count != '0) begin
            ovf_count <= ovf_count - ID_W'(1);
            state     <= S_IDLE;
          end else if (can_write) begin
            if (!stack_empty) level <= lvl_dec;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_element_tree_builder.sv
// Bench for element_tree_builder: directed vector table, hand-written stall,
// drop and reset sequences, and random events against a per-event tree model.
module tb_element_tree_builder;
  localparam int REC_W = 36;
  localparam logic [1:0] K_OPEN = 2'd0, K_ATTR = 2'd1, K_CLOSE = 2'd2, K_ERROR = 2'd3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        el_active = 1'b1;
  logic        tag_done = 1'b0;
  logic [2:0]  element_tag = '0;
  logic        is_closing_tag = 1'b0;
  logic        has_attribute = 1'b0;
  logic [2:0]  attribute_type = '0;
  logic [15:0] attribute_value = '0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [1:0]  rec_kind;
  logic [2:0]  rec_tag;
  logic [3:0]  rec_depth;
  logic [7:0]  rec_id;
  logic [2:0]  rec_attr_type;
  logic [15:0] rec_attr_value;
  logic        busy, overrun;
  logic [1:0]  fsm_state;

  element_tree_builder dut (
    .clock(clock), .resetn(resetn), .el_active(el_active), .tag_done(tag_done),
    .element_tag(element_tag), .is_closing_tag(is_closing_tag),
    .has_attribute(has_attribute), .attribute_type(attribute_type),
    .attribute_value(attribute_value), .rec_ready(rec_ready),
    .rec_valid(rec_valid), .rec_kind(rec_kind), .rec_tag(rec_tag),
    .rec_depth(rec_depth), .rec_id(rec_id), .rec_attr_type(rec_attr_type),
    .rec_attr_value(rec_attr_value), .busy(busy), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

  always @(posedge clock) begin
    #1;
    if (ready_mode == 2) rec_ready = 1'($urandom_range(0, 1));
    else rec_ready = (ready_mode == 1);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, required finish before 800us");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];

  always @(negedge clock)
    if (resetn && rec_valid && rec_ready)
      got_q.push_back({rec_kind, rec_tag, rec_depth, rec_id, rec_attr_type, rec_attr_value});

  function automatic logic [REC_W-1:0] mk(input logic [1:0] k, input logic [2:0] t,
      input logic [3:0] d, input logic [7:0] i, input logic [2:0] at, input logic [15:0] av);
    return {k, t, d, i, at, av};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_records(input string name);
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check(name, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model (one call per tag event) ----------------
  int         m_level, m_ovf;
  logic [2:0] m_tag [8];
  logic [7:0] m_id  [8];
  logic [7:0] m_next;
  logic       m_overrun;
  logic [2:0]  ev_type [6];
  logic [15:0] ev_val  [6];

  task automatic model_reset();
    m_level = 0; m_ovf = 0; m_next = '0; m_overrun = 1'b0;
  endtask

  task automatic model_event(input bit close, input logic [2:0] tag, input int n);
    if (n > 4) m_overrun = 1'b1;
    if (!close) begin
      if (m_level == 8) begin
        exp_q.push_back(mk(K_ERROR, tag, 4'd8, 8'd0, 3'd0, 16'd0));
        m_ovf++;
      end else begin
        exp_q.push_back(mk(K_OPEN, tag, 4'(m_level), m_next, 3'd0, 16'd0));
        for (int k = 0; k < n && k < 4; k++)
          exp_q.push_back(mk(K_ATTR, tag, 4'(m_level), m_next, ev_type[k], ev_val[k]));
        m_tag[m_level] = tag;
        m_id[m_level]  = m_next;
        m_level++;
        m_next++;
      end
    end else if (m_ovf > 0) begin
      m_ovf--;
    end else if (m_level == 0) begin
      exp_q.push_back(mk(K_ERROR, tag, 4'd0, 8'd0, 3'd0, 16'd0));
    end else begin
      m_level--;
      exp_q.push_back(mk((m_tag[m_level] == tag) ? K_CLOSE : K_ERROR, m_tag[m_level],
                         4'(m_level), m_id[m_level], 3'd0, 16'd0));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; tag_done = 1'b0; has_attribute = 1'b0; el_active = 1'b1;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    model_reset();
  endtask

  task automatic set_attrs(input logic [2:0] tag);
    for (int k = 0; k < 6; k++) begin
      ev_type[k] = 3'(k + 1);
      ev_val[k]  = 16'((k + 1) * 4096 + int'(tag));
    end
  endtask

  task automatic send_attrs(input int n);
    for (int k = 0; k < n; k++) begin
      attribute_type = ev_type[k];
      attribute_value = ev_val[k];
      has_attribute = 1'b1;
      tick();
      has_attribute = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_tag(input bit close, input logic [2:0] tag);
    element_tag = tag;
    is_closing_tag = close;
    tag_done = 1'b1;
    tick();
    tag_done = 1'b0;
  endtask

  task automatic send_event(input bit close, input logic [2:0] tag, input int n);
    send_attrs(n);
    pulse_tag(close, tag);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || rec_valid) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy=%0b rec_valid=%0b, required both 0 within 500 cycles",
               name, busy, rec_valid);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    bit         close;
    logic [2:0] tag;
    int         nattr;
    int         nrec;
    logic [1:0] kind;
    logic [2:0] etag;
    logic [3:0] depth;
    logic [7:0] id;
    bit         ovr;
  } vec_t;

  vec_t tbl [40];
  int   nv = 0;

  task automatic add(input bit rst, input bit close, input logic [2:0] tag, input int nattr,
      input int nrec, input logic [1:0] kind, input logic [2:0] etag, input logic [3:0] depth,
      input logic [7:0] id, input bit ovr);
    tbl[nv] = '{rst, close, tag, nattr, nrec, kind, etag, depth, id, ovr};
    nv++;
  endtask

  initial begin
    vec_t v;
    do_reset();
    check("reset_outputs", 64'({rec_valid, rec_kind, rec_tag, rec_depth, rec_id, rec_attr_type,
                                rec_attr_value, busy, overrun, fsm_state}), 64'd0);

    // <div><p></p></div>  (div=1, p=2)
    add(1, 0, 3'd1, 0, 1, K_OPEN,  3'd1, 4'd0, 8'd0, 0);
    add(0, 0, 3'd2, 0, 1, K_OPEN,  3'd2, 4'd1, 8'd1, 0);
    add(0, 1, 3'd2, 0, 1, K_CLOSE, 3'd2, 4'd1, 8'd1, 0);
    add(0, 1, 3'd1, 0, 1, K_CLOSE, 3'd1, 4'd0, 8'd0, 0);
    // <a x y></a>, then an element carrying 5 attributes
    add(1, 0, 3'd3, 2, 3, K_OPEN,  3'd3, 4'd0, 8'd0, 0);
    add(0, 1, 3'd3, 0, 1, K_CLOSE, 3'd3, 4'd0, 8'd0, 0);
    add(0, 0, 3'd4, 5, 5, K_OPEN,  3'd4, 4'd0, 8'd1, 1);
    add(0, 1, 3'd4, 0, 1, K_CLOSE, 3'd4, 4'd0, 8'd1, 1);
    // nine nested opens against an eight-deep stack, then nine closes
    for (int d = 0; d < 8; d++)
      add(d == 0, 0, 3'((d % 7) + 1), 0, 1, K_OPEN, 3'((d % 7) + 1), 4'(d), 8'(d), 0);
    add(0, 0, 3'd6, 0, 1, K_ERROR, 3'd6, 4'd8, 8'd0, 0);
    add(0, 1, 3'd6, 0, 0, K_ERROR, 3'd6, 4'd0, 8'd0, 0);
    for (int d = 7; d >= 0; d--)
      add(0, 1, 3'((d % 7) + 1), 0, 1, K_CLOSE, 3'((d % 7) + 1), 4'(d), 8'(d), 0);
    // <div></p> then </div> on an empty stack
    add(1, 0, 3'd1, 0, 1, K_OPEN,  3'd1, 4'd0, 8'd0, 0);
    add(0, 1, 3'd2, 0, 1, K_ERROR, 3'd1, 4'd0, 8'd0, 0);
    add(0, 1, 3'd1, 0, 1, K_ERROR, 3'd1, 4'd0, 8'd0, 0);

    for (int i = 0; i < nv; i++) begin
      v = tbl[i];
      if (v.rst) do_reset();
      ready_mode = 1;
      set_attrs(v.tag);
      send_event(v.close, v.tag, v.nattr);
      wait_idle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_nrec", i), 64'(got_q.size()), 64'(v.nrec));
      if (got_q.size() > 0 && v.nrec > 0)
        check($sformatf("tbl%0d_first", i), 64'(got_q[0]),
              64'(mk(v.kind, v.etag, v.depth, v.id, 3'd0, 16'd0)));
      for (int k = 1; k < got_q.size() && k < v.nrec; k++)
        check($sformatf("tbl%0d_attr%0d", i, k), 64'(got_q[k]),
              64'(mk(K_ATTR, v.etag, v.depth, v.id, ev_type[k-1], ev_val[k-1])));
      check($sformatf("tbl%0d_overrun", i), 64'(overrun), 64'(v.ovr));
      got_q.delete();
    end

    // FIFO backpressure: 10 records with rec_ready low, then release
    do_reset();
    ready_mode = 0;
    set_attrs(3'd1);
    send_event(0, 3'd1, 4);
    model_event(0, 3'd1, 4);
    set_attrs(3'd2);
    send_event(0, 3'd2, 4);
    model_event(0, 3'd2, 4);
    repeat (20) tick();
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_state", 64'(fsm_state), 64'd2);
    check("stall_valid", 64'(rec_valid), 64'd1);
    check("stall_head", 64'({rec_kind, rec_tag, rec_depth, rec_id, rec_attr_type, rec_attr_value}),
          64'(mk(K_OPEN, 3'd1, 4'd0, 8'd0, 3'd0, 16'd0)));
    ready_mode = 1;
    wait_idle("stall");
    check_records("stall");
    check("stall_overrun", 64'(overrun), 64'd0);

    // second tag edge while the first element's attributes are being emitted
    do_reset();
    ready_mode = 1;
    set_attrs(3'd3);
    send_attrs(4);
    pulse_tag(0, 3'd3);
    tick();
    element_tag = 3'd5;
    is_closing_tag = 1'b1;
    tag_done = 1'b1;
    tick();
    tag_done = 1'b0;
    model_event(0, 3'd3, 4);
    wait_idle("drop");
    check_records("drop");
    check("drop_overrun", 64'(overrun), 64'd1);

    // reset asserted in the middle of an emission
    do_reset();
    ready_mode = 0;
    set_attrs(3'd4);
    send_attrs(3);
    pulse_tag(0, 3'd4);
    tick();
    check("midrst_pre", 64'({rec_valid, busy, fsm_state}), 64'b1110);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_outputs", 64'({rec_valid, busy, overrun, fsm_state}), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    model_reset();
    ready_mode = 1;
    set_attrs(3'd5);
    send_event(0, 3'd5, 1);
    model_event(0, 3'd5, 1);
    wait_idle("post_reset");
    check_records("post_reset");

    // el_active low discards attributes captured so far
    set_attrs(3'd6);
    send_attrs(2);
    el_active = 1'b0;
    tick();
    el_active = 1'b1;
    pulse_tag(0, 3'd6);
    model_event(0, 3'd6, 0);
    wait_idle("el_active");
    check_records("el_active");

    // random events with random backpressure
    do_reset();
    ready_mode = 2;
    for (int e = 0; e < 80; e++) begin
      bit         close;
      logic [2:0] tag;
      int         n;
      close = ($urandom_range(0, 9) < 4);
      tag = 3'($urandom_range(0, 7));
      n = $urandom_range(0, 5);
      for (int k = 0; k < 6; k++) begin
        ev_type[k] = 3'($urandom_range(0, 7));
        ev_val[k]  = 16'($urandom_range(0, 65535));
      end
      send_event(close, tag, n);
      model_event(close, tag, n);
      wait_idle($sformatf("rand%0d", e));
      check_records($sformatf("rand%0d", e));
      check($sformatf("rand%0d_overrun", e), 64'(overrun), 64'(m_overrun));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/element_tree_builder.md
Name: element_tree_builder

Overview:
- Sits directly downstream of element_parser and consumes its per-tag outputs.
- Tracks open/close nesting on a tag stack and assigns node IDs.
- Emits a serialized record stream (OPEN, ATTR, CLOSE, ERROR) through an output FIFO with valid/ready handshake.
- Feeds the layout/render stage with a well-formed, depth-annotated node stream.

Parameters:
TAG_W, 3, width of element_tag (matches `ELE_TAG_BITES)
ATYPE_W, 3, width of attribute_type (matches `ATTRIBUTE_TYPE_BITES)
AVAL_W, 16, width of attribute_value (matches `ATTRIBUTE_VAL_BITES)
STACK_DEPTH, 8, maximum nesting levels held on the stack
MAX_ATTR, 4, attributes buffered per element
FIFO_DEPTH, 8, output record FIFO entries (power of 2)
ID_W, 8, node ID width

Ports:
clock  in  1  global clock, rising edge
resetn  in  1  asynchronous active-low reset
el_active  in  1  parser enable (state_enable of element_parser); low clears the attribute capture buffer
tag_done  in  1  parser has_finished
element_tag  in  TAG_W  parser tag code
is_closing_tag  in  1  parser closing flag
has_attribute  in  1  parser attribute strobe
attribute_type  in  ATYPE_W  parser attribute type
attribute_value  in  AVAL_W  parser attribute value
rec_ready  in  1  downstream accepts record
rec_valid  out  1  record available
rec_kind  out  2  0=OPEN 1=ATTR 2=CLOSE 3=ERROR
rec_tag  out  TAG_W  element tag
rec_depth  out  $clog2(STACK_DEPTH)+1  nesting depth
rec_id  out  ID_W  node ID
rec_attr_type  out  ATYPE_W  ATTR only, else 0
rec_attr_value  out  AVAL_W  ATTR only, else 0
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: input event dropped or attribute overflow

Behaviour:
- Reset (async on resetn low): all outputs 0, stack empty, FIFO empty, next_id=0, ovf_count=0, FSM=IDLE, capture buffer empty.
- Event detection: tag event = tag_done high now and low in the previous cycle. Attribute event = rising edge of has_attribute. Both are registered edge detectors; the previous-value registers reset to 0.
- Attribute capture: on an attribute event, store {type,value} if count<MAX_ATTR; otherwise drop and set overrun. Cleared when el_active=0.
- Tag event in IDLE: snapshot tag, closing flag, and capture buffer into the emit buffer; clear the capture buffer in the same cycle. Capture continues independently afterwards.
- Tag event when not IDLE: event dropped, overrun set.
- FSM states and transitions:
  - IDLE: on a tag event, go to OPEN_CHK if opening, else CLOSE_CHK.
  - OPEN_CHK, stack not full: write OPEN {tag, depth=level before push, id=next_id}; push {tag,id}; next_id++ (wraps mod 2^ID_W); go to EMIT_ATTR.
  - OPEN_CHK, stack full: write ERROR {tag, depth=STACK_DEPTH, id=0}; ovf_count++; go to IDLE. Attributes are discarded.
  - EMIT_ATTR: one ATTR per cycle {tag, depth, id of the element just opened, type, value}, in arrival order; go to IDLE after the last one, or immediately if none.
  - CLOSE_CHK, ovf_count>0: ovf_count--, no record, go to IDLE.
  - CLOSE_CHK, stack empty: write ERROR {tag, depth 0, id 0}; go to IDLE.
  - CLOSE_CHK, top tag == tag: pop; write CLOSE {tag, depth=level after pop, id=top id}.
  - CLOSE_CHK, top tag != tag: pop anyway; write ERROR {tag=top tag, depth=level after pop, id=top id}.
  - Attributes on closing tags are always discarded.
- FIFO stall: any write state stalls in place while the FIFO is full. No state advance and no stack change occur until the write succeeds.
- Output handshake: a record transfers when rec_valid && rec_ready. rec_* fields are held stable while rec_valid=1 and rec_ready=0. Simultaneous read and write on a full FIFO is allowed.
- Latency: tag event in cycle T; the record is written at the end of T+1. With the FIFO empty, rec_valid rises in T+2.
- resetn deasserted mid-emit: all state is lost and partial records are discarded.

Test Plan:
- Nested open/close `<div><p></p></div>`, rec_ready=1 -> OPEN(div,d0,id0), OPEN(p,d1,id1), CLOSE(p,d1,id1), CLOSE(div,d0,id0).
- `<a x y>` with 2 attribute strobes -> OPEN(a,d0,id0), ATTR t/v #1, ATTR t/v #2 on consecutive cycles. Then 5 attributes on one tag -> 4 ATTR records, overrun=1.
- 9 nested opens with STACK_DEPTH=8 -> 8 OPENs, 1 ERROR(depth 8). The 9th close produces no record. The remaining 8 closes produce CLOSE with depth 7..0.
- Mismatch `<div></p>` -> ERROR(tag=div,d0,id0), stack empty. A further `</div>` -> ERROR(div,d0,id0).
- rec_ready=0 while 10 records are generated -> FIFO holds 8, FSM stalls, busy=1. Releasing rec_ready -> all 10 records arrive in order with no loss.
- Second tag_done edge one cycle into a 4-attribute EMIT_ATTR -> second event dropped, overrun=1. Asserting resetn=0 mid-stream -> rec_valid=0 immediately and next_id restarts at 0.
